// File: rtl/id_top.sv
// Instruction-decode stage: registers the fetched word, decodes it, resolves
// operands with EX/MEM forwarding, resolves branches/jumps in ID, detects
// load-use hazards and drives the registered ID/EX bundle.
module id_top (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    // fetch side
    input  logic        if_en,
    input  logic [29:0] if_pc,
    input  logic [31:0] if_insn,
    // register file
    output logic [4:0]  gpr_rd_addr_0,
    output logic [4:0]  gpr_rd_addr_1,
    input  logic [31:0] gpr_rd_data_0,
    input  logic [31:0] gpr_rd_data_1,
    // EX-stage forwarding
    input  logic        ex_en,
    input  logic        ex_gpr_we_,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_dst_addr,
    input  logic [31:0] ex_fwd_data,
    // MEM-stage forwarding
    input  logic        mem_en,
    input  logic        mem_gpr_we_,
    input  logic [4:0]  mem_dst_addr,
    input  logic [31:0] mem_fwd_data,
    // redirect and hazard
    output logic        br_taken,
    output logic [29:0] br_addr,
    output logic        ld_hazard,
    // ID/EX bundle
    output logic        id_en,
    output logic [29:0] id_pc,
    output logic [3:0]  id_alu_op,
    output logic [31:0] id_alu_in_0,
    output logic [31:0] id_alu_in_1,
    output logic [1:0]  id_mem_op,
    output logic [31:0] id_mem_wr_data,
    output logic [4:0]  id_dst_addr,
    output logic        id_gpr_we_,
    output logic        id_undef
);

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned OW = 6;

    // opcodes
    localparam logic [OW-1:0] OP_ANDR  = 6'h00;
    localparam logic [OW-1:0] OP_ANDI  = 6'h01;
    localparam logic [OW-1:0] OP_ORR   = 6'h02;
    localparam logic [OW-1:0] OP_ORI   = 6'h03;
    localparam logic [OW-1:0] OP_XORR  = 6'h04;
    localparam logic [OW-1:0] OP_XORI  = 6'h05;
    localparam logic [OW-1:0] OP_ADDSR = 6'h06;
    localparam logic [OW-1:0] OP_ADDSI = 6'h07;
    localparam logic [OW-1:0] OP_ADDUR = 6'h08;
    localparam logic [OW-1:0] OP_ADDUI = 6'h09;
    localparam logic [OW-1:0] OP_SUBSR = 6'h0A;
    localparam logic [OW-1:0] OP_SUBUR = 6'h0B;
    localparam logic [OW-1:0] OP_SHRLR = 6'h0C;
    localparam logic [OW-1:0] OP_SHRLI = 6'h0D;
    localparam logic [OW-1:0] OP_SHLLR = 6'h0E;
    localparam logic [OW-1:0] OP_SHLLI = 6'h0F;
    localparam logic [OW-1:0] OP_BE    = 6'h10;
    localparam logic [OW-1:0] OP_BNE   = 6'h11;
    localparam logic [OW-1:0] OP_BSGT  = 6'h12;
    localparam logic [OW-1:0] OP_BUGT  = 6'h13;
    localparam logic [OW-1:0] OP_JMP   = 6'h14;
    localparam logic [OW-1:0] OP_CALL  = 6'h15;
    localparam logic [OW-1:0] OP_LDW   = 6'h16;
    localparam logic [OW-1:0] OP_STW   = 6'h17;

    // ALU operations
    localparam logic [3:0] ALU_THROUGH = 4'd0;
    localparam logic [3:0] ALU_AND     = 4'd1;
    localparam logic [3:0] ALU_OR      = 4'd2;
    localparam logic [3:0] ALU_XOR     = 4'd3;
    localparam logic [3:0] ALU_ADDS    = 4'd4;
    localparam logic [3:0] ALU_ADDU    = 4'd5;
    localparam logic [3:0] ALU_SUBS    = 4'd6;
    localparam logic [3:0] ALU_SUBU    = 4'd7;
    localparam logic [3:0] ALU_SHRL    = 4'd8;
    localparam logic [3:0] ALU_SHLL    = 4'd9;

    // memory operations
    localparam logic [1:0] MEM_NOP   = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;

    localparam logic [RW-1:0] LINK_REG = 5'd31;

    logic [OW-1:0] op;
    logic [RW-1:0] ra;
    logic [RW-1:0] rb;
    logic [RW-1:0] rc;
    logic [15:0]   imm;
    logic [DW-1:0] imm_sext;
    logic [DW-1:0] imm_zext;
    logic [DW-1:0] imm_shamt;

    logic [DW-1:0] opnd_a;
    logic [DW-1:0] opnd_b;

    logic [3:0]    dec_alu_op;
    logic [DW-1:0] dec_in_0;
    logic [DW-1:0] dec_in_1;
    logic [1:0]    dec_mem_op;
    logic [DW-1:0] dec_wr_data;
    logic [RW-1:0] dec_dst;
    logic          dec_gpr_we_;
    logic          dec_undef;
    logic          is_branch;
    logic          is_jump;
    logic          br_cond;
    logic [AW-1:0] br_target;

    // instruction field extraction
    assign op        = if_insn[31:26];
    assign ra        = if_insn[25:21];
    assign rb        = if_insn[20:16];
    assign rc        = if_insn[15:11];
    assign imm       = if_insn[15:0];
    assign imm_sext  = {{16{imm[15]}}, imm};
    assign imm_zext  = {16'h0000, imm};
    assign imm_shamt = {27'h0, imm[4:0]};

    assign gpr_rd_addr_0 = ra;
    assign gpr_rd_addr_1 = rb;

    // operand forwarding: EX beats MEM beats the register file
    always_comb begin
        opnd_a = gpr_rd_data_0;
        if (ex_en && !ex_gpr_we_ && (ex_dst_addr == ra)) begin
            opnd_a = ex_fwd_data;
        end else if (mem_en && !mem_gpr_we_ && (mem_dst_addr == ra)) begin
            opnd_a = mem_fwd_data;
        end

        opnd_b = gpr_rd_data_1;
        if (ex_en && !ex_gpr_we_ && (ex_dst_addr == rb)) begin
            opnd_b = ex_fwd_data;
        end else if (mem_en && !mem_gpr_we_ && (mem_dst_addr == rb)) begin
            opnd_b = mem_fwd_data;
        end
    end

    // opcode decode into the ID/EX payload and branch condition
    always_comb begin
        dec_alu_op  = ALU_THROUGH;
        dec_in_0    = opnd_a;
        dec_in_1    = opnd_b;
        dec_mem_op  = MEM_NOP;
        dec_wr_data = opnd_b;
        dec_dst     = rc;
        dec_gpr_we_ = 1'b1;
        dec_undef   = 1'b0;
        is_branch   = 1'b0;
        is_jump     = 1'b0;
        br_cond     = 1'b0;

        case (op)
            OP_ANDR:  begin dec_alu_op = ALU_AND;  dec_gpr_we_ = 1'b0; end
            OP_ORR:   begin dec_alu_op = ALU_OR;   dec_gpr_we_ = 1'b0; end
            OP_XORR:  begin dec_alu_op = ALU_XOR;  dec_gpr_we_ = 1'b0; end
            OP_ADDSR: begin dec_alu_op = ALU_ADDS; dec_gpr_we_ = 1'b0; end
            OP_ADDUR: begin dec_alu_op = ALU_ADDU; dec_gpr_we_ = 1'b0; end
            OP_SUBSR: begin dec_alu_op = ALU_SUBS; dec_gpr_we_ = 1'b0; end
            OP_SUBUR: begin dec_alu_op = ALU_SUBU; dec_gpr_we_ = 1'b0; end
            OP_SHRLR: begin dec_alu_op = ALU_SHRL; dec_gpr_we_ = 1'b0; end
            OP_SHLLR: begin dec_alu_op = ALU_SHLL; dec_gpr_we_ = 1'b0; end
            OP_ANDI: begin
                dec_alu_op  = ALU_AND;
                dec_in_1    = imm_zext;
                dec_dst     = rb;
                dec_gpr_we_ = 1'b0;
            end
            OP_ORI: begin
                dec_alu_op  = ALU_OR;
                dec_in_1    = imm_zext;
                dec_dst     = rb;
                dec_gpr_we_ = 1'b0;
            end
            OP_XORI: begin
                dec_alu_op  = ALU_XOR;
                dec_in_1    = imm_zext;
                dec_dst     = rb;
                dec_gpr_we_ = 1'b0;
            end
            OP_ADDSI: begin
                dec_alu_op  = ALU_ADDS;
                dec_in_1    = imm_sext;
                dec_dst     = rb;
                dec_gpr_we_ = 1'b0;
            end
            OP_ADDUI: begin
                dec_alu_op  = ALU_ADDU;
                dec_in_1    = imm_zext;
                dec_dst     = rb;
                dec_gpr_we_ = 1'b0;
            end
            OP_SHRLI: begin
                dec_alu_op  = ALU_SHRL;
                dec_in_1    = imm_shamt;
                dec_dst     = rb;
                dec_gpr_we_ = 1'b0;
            end
            OP_SHLLI: begin
                dec_alu_op  = ALU_SHLL;
                dec_in_1    = imm_shamt;
                dec_dst     = rb;
                dec_gpr_we_ = 1'b0;
            end
            OP_BE: begin
                is_branch = 1'b1;
                br_cond   = (opnd_a == opnd_b);
            end
            OP_BNE: begin
                is_branch = 1'b1;
                br_cond   = (opnd_a != opnd_b);
            end
            OP_BSGT: begin
                is_branch = 1'b1;
                br_cond   = ($signed(opnd_a) < $signed(opnd_b));
            end
            OP_BUGT: begin
                is_branch = 1'b1;
                br_cond   = (opnd_a < opnd_b);
            end
            OP_JMP: begin
                is_jump = 1'b1;
            end
            OP_CALL: begin
                is_jump     = 1'b1;
                dec_in_0    = {if_pc, 2'b00};
                dec_dst     = LINK_REG;
                dec_gpr_we_ = 1'b0;
            end
            OP_LDW: begin
                dec_alu_op  = ALU_ADDU;
                dec_in_1    = imm_sext;
                dec_mem_op  = MEM_LOAD;
                dec_dst     = rb;
                dec_gpr_we_ = 1'b0;
            end
            OP_STW: begin
                dec_alu_op = ALU_ADDU;
                dec_in_1   = imm_sext;
                dec_mem_op = MEM_STORE;
            end
            default: begin
                dec_undef = 1'b1;
            end
        endcase
    end

    // load-use hazard compares both source fields whatever the opcode
    assign ld_hazard = ex_en & ex_is_load & ~ex_gpr_we_ & if_en &
                       ((ex_dst_addr == ra) | (ex_dst_addr == rb));

    // redirect: PC-relative for branches, register-indirect for JMP/CALL
    assign br_target = is_branch ? (if_pc + imm_sext[AW-1:0]) : opnd_a[DW-1:2];
    assign br_taken  = if_en & ~ld_hazard & (br_cond | is_jump);
    assign br_addr   = br_taken ? br_target : if_pc;

    // ID/EX pipeline register: reset, hold, bubble or capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            id_en          <= 1'b0;
            id_pc          <= '0;
            id_alu_op      <= ALU_THROUGH;
            id_alu_in_0    <= '0;
            id_alu_in_1    <= '0;
            id_mem_op      <= MEM_NOP;
            id_mem_wr_data <= '0;
            id_dst_addr    <= '0;
            id_gpr_we_     <= 1'b1;
            id_undef       <= 1'b0;
        end else if (!stall) begin
            if (flush || ld_hazard || !if_en) begin
                // payload fields keep their previous values
                id_en      <= 1'b0;
                id_gpr_we_ <= 1'b1;
                id_mem_op  <= MEM_NOP;
                id_undef   <= 1'b0;
            end else begin
                id_en          <= 1'b1;
                id_pc          <= if_pc;
                id_alu_op      <= dec_alu_op;
                id_alu_in_0    <= dec_in_0;
                id_alu_in_1    <= dec_in_1;
                id_mem_op      <= dec_mem_op;
                id_mem_wr_data <= dec_wr_data;
                id_dst_addr    <= dec_dst;
                id_gpr_we_     <= dec_gpr_we_;
                id_undef       <= dec_undef;
            end
        end
    end

endmodule

// File: tb/tb_id_top.sv
// Self-checking bench for id_top: directed scenarios followed by randomized
// traffic, all checked against an opcode-table reference model.
module tb_id_top;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        if_en;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic [4:0]  gpr_rd_addr_0;
    logic [4:0]  gpr_rd_addr_1;
    logic [31:0] gpr_rd_data_0;
    logic [31:0] gpr_rd_data_1;
    logic        ex_en;
    logic        ex_gpr_we_;
    logic        ex_is_load;
    logic [4:0]  ex_dst_addr;
    logic [31:0] ex_fwd_data;
    logic        mem_en;
    logic        mem_gpr_we_;
    logic [4:0]  mem_dst_addr;
    logic [31:0] mem_fwd_data;
    logic        br_taken;
    logic [29:0] br_addr;
    logic        ld_hazard;
    logic        id_en;
    logic [29:0] id_pc;
    logic [3:0]  id_alu_op;
    logic [31:0] id_alu_in_0;
    logic [31:0] id_alu_in_1;
    logic [1:0]  id_mem_op;
    logic [31:0] id_mem_wr_data;
    logic [4:0]  id_dst_addr;
    logic        id_gpr_we_;
    logic        id_undef;

    logic [31:0] rf [32];

    assign gpr_rd_data_0 = rf[gpr_rd_addr_0];
    assign gpr_rd_data_1 = rf[gpr_rd_addr_1];

    always #5 clk = ~clk;

    id_top dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .if_en          (if_en),
        .if_pc          (if_pc),
        .if_insn        (if_insn),
        .gpr_rd_addr_0  (gpr_rd_addr_0),
        .gpr_rd_addr_1  (gpr_rd_addr_1),
        .gpr_rd_data_0  (gpr_rd_data_0),
        .gpr_rd_data_1  (gpr_rd_data_1),
        .ex_en          (ex_en),
        .ex_gpr_we_     (ex_gpr_we_),
        .ex_is_load     (ex_is_load),
        .ex_dst_addr    (ex_dst_addr),
        .ex_fwd_data    (ex_fwd_data),
        .mem_en         (mem_en),
        .mem_gpr_we_    (mem_gpr_we_),
        .mem_dst_addr   (mem_dst_addr),
        .mem_fwd_data   (mem_fwd_data),
        .br_taken       (br_taken),
        .br_addr        (br_addr),
        .ld_hazard      (ld_hazard),
        .id_en          (id_en),
        .id_pc          (id_pc),
        .id_alu_op      (id_alu_op),
        .id_alu_in_0    (id_alu_in_0),
        .id_alu_in_1    (id_alu_in_1),
        .id_mem_op      (id_mem_op),
        .id_mem_wr_data (id_mem_wr_data),
        .id_dst_addr    (id_dst_addr),
        .id_gpr_we_     (id_gpr_we_),
        .id_undef       (id_undef)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // single comparison point
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // instruction classes of the reference model
    localparam int K_R = 0, K_IZ = 1, K_IS = 2, K_ISH = 3, K_BR = 4,
                   K_JMP = 5, K_CALL = 6, K_LD = 7, K_ST = 8, K_UND = 9;

    function automatic int kind_of(input logic [5:0] op);
        case (op)
            6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0E: return K_R;
            6'h01, 6'h03, 6'h05, 6'h09: return K_IZ;
            6'h07: return K_IS;
            6'h0D, 6'h0F: return K_ISH;
            6'h10, 6'h11, 6'h12, 6'h13: return K_BR;
            6'h14: return K_JMP;
            6'h15: return K_CALL;
            6'h16: return K_LD;
            6'h17: return K_ST;
            default: return K_UND;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] op);
        case (op)
            6'h00, 6'h01: return 4'd1;
            6'h02, 6'h03: return 4'd2;
            6'h04, 6'h05: return 4'd3;
            6'h06, 6'h07: return 4'd4;
            6'h08, 6'h09, 6'h16, 6'h17: return 4'd5;
            6'h0A: return 4'd6;
            6'h0B: return 4'd7;
            6'h0C, 6'h0D: return 4'd8;
            6'h0E, 6'h0F: return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r);
        if (ex_en && !ex_gpr_we_ && ex_dst_addr == r) return ex_fwd_data;
        if (mem_en && !mem_gpr_we_ && mem_dst_addr == r) return mem_fwd_data;
        return rf[r];
    endfunction

    // expected ID/EX register contents and which payload fields are meaningful
    logic        e_en, e_we, e_undef;
    logic [1:0]  e_mem;
    logic [29:0] e_pc;
    logic [3:0]  e_op;
    logic [31:0] e_in0, e_in1, e_wd;
    logic [4:0]  e_dst;
    bit          c_pc, c_alu, c_in1, c_dst, c_wd;

    // check the combinational outputs, then advance the model to the next edge
    task automatic settle();
        logic [5:0]  op;
        logic [4:0]  ra, rb, rc;
        logic [31:0] a, b, sx, zx;
        logic [29:0] tgt;
        int          k;
        bit          haz, cond, taken;
        #1;
        op = if_insn[31:26];
        ra = if_insn[25:21];
        rb = if_insn[20:16];
        rc = if_insn[15:11];
        zx = {16'h0, if_insn[15:0]};
        sx = {{16{if_insn[15]}}, if_insn[15:0]};
        a  = fwd(ra);
        b  = fwd(rb);
        k  = kind_of(op);
        case (op)
            6'h10:   cond = (a == b);
            6'h11:   cond = (a != b);
            6'h12:   cond = ($signed(a) < $signed(b));
            6'h13:   cond = (a < b);
            default: cond = 1'b0;
        endcase
        haz   = ex_en && ex_is_load && !ex_gpr_we_ && if_en && (ex_dst_addr == ra || ex_dst_addr == rb);
        taken = if_en && !haz && (cond || k == K_JMP || k == K_CALL);
        tgt   = if_pc + sx[29:0];
        chk("gpr_rd_addr_0", gpr_rd_addr_0, ra);
        chk("gpr_rd_addr_1", gpr_rd_addr_1, rb);
        chk("ld_hazard", ld_hazard, haz);
        chk("br_taken", br_taken, taken);
        if (!taken)         chk("br_addr", br_addr, if_pc);
        else if (k == K_BR) chk("br_addr", br_addr, tgt);
        else                chk("br_addr", br_addr, a[31:2]);

        if (!reset) begin
            e_en = 0; e_we = 1; e_undef = 0; e_mem = 0; e_pc = 0; e_op = 0;
            e_in0 = 0; e_in1 = 0; e_wd = 0; e_dst = 0;
            c_pc = 1; c_alu = 1; c_in1 = 1; c_dst = 1; c_wd = 1;
        end else if (stall) begin
            // everything held
        end else if (flush || haz || !if_en) begin
            e_en = 0; e_we = 1; e_undef = 0; e_mem = 0;
            c_pc = 0; c_alu = 0; c_in1 = 0; c_dst = 0; c_wd = 0;
        end else begin
            e_en = 1; e_pc = if_pc; e_undef = (k == K_UND);
            e_op = alu_of(op); e_in0 = a; e_in1 = b; e_wd = b;
            e_we = 1; e_mem = 0; e_dst = rb;
            c_pc = 1; c_alu = 0; c_in1 = 0; c_dst = 0; c_wd = 0;
            case (k)
                K_R:    begin e_we = 0; e_dst = rc; c_alu = 1; c_in1 = 1; c_dst = 1; end
                K_IZ:   begin e_we = 0; e_in1 = zx; c_alu = 1; c_in1 = 1; c_dst = 1; end
                K_IS:   begin e_we = 0; e_in1 = sx; c_alu = 1; c_in1 = 1; c_dst = 1; end
                K_ISH:  begin e_we = 0; e_in1 = {27'h0, zx[4:0]}; c_alu = 1; c_in1 = 1; c_dst = 1; end
                K_CALL: begin e_we = 0; e_in0 = {if_pc, 2'b00}; e_dst = 5'd31; c_alu = 1; c_dst = 1; end
                K_LD:   begin e_we = 0; e_mem = 1; e_in1 = sx; c_alu = 1; c_in1 = 1; c_dst = 1; end
                K_ST:   begin e_mem = 2; e_in1 = sx; c_alu = 1; c_in1 = 1; c_wd = 1; end
                default: ;
            endcase
        end
    endtask

    // clock edge, then compare the registered bundle
    task automatic tick();
        @(posedge clk);
        #1;
        chk("id_en", id_en, e_en);
        chk("id_gpr_we_", id_gpr_we_, e_we);
        chk("id_mem_op", id_mem_op, e_mem);
        chk("id_undef", id_undef, e_undef);
        if (c_pc)  chk("id_pc", id_pc, e_pc);
        if (c_alu) chk("id_alu_op", id_alu_op, e_op);
        if (c_alu) chk("id_alu_in_0", id_alu_in_0, e_in0);
        if (c_in1) chk("id_alu_in_1", id_alu_in_1, e_in1);
        if (c_dst) chk("id_dst_addr", id_dst_addr, e_dst);
        if (c_wd)  chk("id_mem_wr_data", id_mem_wr_data, e_wd);
    endtask

    task automatic quiet();
        reset = 1; stall = 0; flush = 0; if_en = 1; if_pc = 30'h55;
        ex_en = 0; ex_gpr_we_ = 1; ex_is_load = 0; ex_dst_addr = 0; ex_fwd_data = 0;
        mem_en = 0; mem_gpr_we_ = 1; mem_dst_addr = 0; mem_fwd_data = 0;
    endtask

    function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] ra,
                                         input logic [4:0] rb, input logic [4:0] rc);
        return {op, ra, rb, rc, 11'h0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] ra,
                                         input logic [4:0] rb, input logic [15:0] imm);
        return {op, ra, rb, imm};
    endfunction

    function automatic logic [4:0] rreg();
        int unsigned s = $urandom_range(0, 4);
        return (s == 4) ? 5'd31 : 5'(s);
    endfunction

    function automatic logic [31:0] rdata();
        int unsigned s = $urandom_range(0, 3);
        if (s == 0) return 32'($urandom_range(0, 3));
        if (s == 1) return 32'h8000_0000 | 32'($urandom_range(0, 3));
        return 32'($urandom);
    endfunction

    task automatic rand_inputs();
        logic [5:0]  op;
        logic [15:0] imm;
        reset = ($urandom_range(0, 49) != 0);
        stall = ($urandom_range(0, 7) == 0);
        flush = ($urandom_range(0, 7) == 0);
        if_en = ($urandom_range(0, 5) != 0);
        if_pc = 30'($urandom);
        op    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 23));
        imm   = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
        if_insn = {op, rreg(), rreg(), imm};
        if (op < 6'h10 && !op[0]) if_insn = mk_r(op, rreg(), rreg(), rreg());
        ex_en        = $urandom_range(0, 1) == 1;
        ex_gpr_we_   = $urandom_range(0, 3) == 0;
        ex_is_load   = $urandom_range(0, 2) == 0;
        ex_dst_addr  = rreg();
        ex_fwd_data  = rdata();
        mem_en       = $urandom_range(0, 1) == 1;
        mem_gpr_we_  = $urandom_range(0, 3) == 0;
        mem_dst_addr = rreg();
        mem_fwd_data = rdata();
        rf[$urandom_range(0, 31)] = rdata();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
        quiet();
        if_insn = 0;

        // reset held two cycles with a changing instruction stream
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            quiet(); reset = 0; if_insn = 32'($urandom);
            settle(); tick();
        end
        chk("rst_id_gpr_we_", id_gpr_we_, 1);
        chk("rst_id_alu_in_0", id_alu_in_0, 0);

        // ADDUI r1 = r2 + 5 right after reset release
        @(negedge clk);
        quiet(); rf[2] = 10; if_insn = mk_i(6'h09, 5'd2, 5'd1, 16'd5);
        settle(); tick();
        chk("addui_op", id_alu_op, 5);
        chk("addui_in_0", id_alu_in_0, 10);
        chk("addui_in_1", id_alu_in_1, 5);
        chk("addui_dst", id_dst_addr, 1);
        chk("addui_we_", id_gpr_we_, 0);

        // stall together with flush holds the previous capture
        @(negedge clk);
        quiet(); stall = 1; flush = 1; if_pc = 30'h77; if_insn = mk_r(6'h02, 5'd4, 5'd5, 5'd6);
        settle(); tick();
        chk("hold_pc", id_pc, 30'h55);
        chk("hold_en", id_en, 1);

        // forwarding priority EX > MEM > register file
        @(negedge clk);
        quiet(); rf[3] = 32'hCC;
        ex_en = 1; ex_gpr_we_ = 0; ex_dst_addr = 3; ex_fwd_data = 32'hAA;
        mem_en = 1; mem_gpr_we_ = 0; mem_dst_addr = 3; mem_fwd_data = 32'hBB;
        if_insn = mk_r(6'h00, 5'd3, 5'd3, 5'd4);
        settle(); tick();
        chk("fwd_ex_in_0", id_alu_in_0, 32'hAA);
        chk("fwd_ex_in_1", id_alu_in_1, 32'hAA);
        @(negedge clk);
        ex_en = 0;
        settle(); tick();
        chk("fwd_mem_in_0", id_alu_in_0, 32'hBB);

        // load-use hazard then normal capture
        @(negedge clk);
        quiet(); ex_en = 1; ex_gpr_we_ = 0; ex_is_load = 1; ex_dst_addr = 5;
        if_insn = mk_r(6'h08, 5'd1, 5'd5, 5'd6);
        settle();
        chk("lu_hazard", ld_hazard, 1);
        chk("lu_br_taken", br_taken, 0);
        tick();
        chk("lu_bubble", id_en, 0);
        @(negedge clk);
        ex_en = 0;
        settle(); tick();
        chk("lu_resume", id_en, 1);

        // BE taken / not taken, and a wrapping target
        @(negedge clk);
        quiet(); rf[1] = 7; rf[2] = 7; if_pc = 30'h100;
        if_insn = mk_i(6'h10, 5'd1, 5'd2, 16'hFFFE);
        settle();
        chk("be_taken", br_taken, 1);
        chk("be_addr", br_addr, 30'h0FE);
        tick();
        @(negedge clk);
        rf[2] = 8;
        settle();
        chk("be_not_taken", br_taken, 0);
        chk("be_fall_addr", br_addr, 30'h100);
        tick();
        @(negedge clk);
        rf[2] = 7; if_pc = 30'h3FFF_FFFF; if_insn = mk_i(6'h10, 5'd1, 5'd2, 16'h0002);
        settle();
        chk("be_wrap_addr", br_addr, 30'h1);
        tick();

        // CALL through r1 = 0x400
        @(negedge clk);
        quiet(); rf[1] = 32'h400; if_pc = 30'h20; if_insn = mk_i(6'h15, 5'd1, 5'd0, 16'h0);
        settle();
        chk("call_addr", br_addr, 30'h100);
        tick();
        chk("call_dst", id_dst_addr, 31);
        chk("call_in_0", id_alu_in_0, 32'h80);
        chk("call_op", id_alu_op, 0);

        // undefined opcode
        @(negedge clk);
        quiet(); if_insn = mk_i(6'h3F, 5'd1, 5'd2, 16'h1234);
        settle(); tick();
        chk("undef_flag", id_undef, 1);
        chk("undef_we_", id_gpr_we_, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rand_inputs();
            settle(); tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
